// File: rtl/ttl74193_pkg.sv
// Shared types and timing defaults for the ttl74193 counter sequencer.
package ttl74193_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    PLO,
    PHI,
    DONE,
    ERR
  } state_t;

  localparam int PULSE_LO_DEF = 4;
  localparam int PULSE_HI_DEF = 4;
  localparam int LD_CYC_DEF   = 2;

  typedef logic [3:0] cnt4_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ttl74193_seq_ctrl_seq_timer.sv
// Loadable down-counter with zero flag; a load of N-1 gives an N-cycle interval.
module seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ttl74193_seq_ctrl.sv
// Drives one ttl74193 through load and single-step CPu/CPd pulses until q reaches target,
// verifying every step against the counter feedback.
module ttl74193_seq_ctrl
  import ttl74193_pkg::*;
#(
  parameter int PULSE_LO = PULSE_LO_DEF,
  parameter int PULSE_HI = PULSE_HI_DEF,
  parameter int LD_CYC   = LD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir,
  input  logic [3:0] start_val,
  input  logic [3:0] target,
  input  logic       abort,
  input  logic [3:0] q,
  input  logic       qcc,
  input  logic       qcb,
  output logic       clr,
  output logic       ld,
  output logic [3:0] data,
  output logic       cpu,
  output logic       cpd,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       wrapped
);

  localparam int TMAX = max3(PULSE_LO, PULSE_HI, LD_CYC);
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  state_t       state;
  logic         dir_r;
  cnt4_t        sv_r;
  cnt4_t        tg_r;
  cnt4_t        exp_q;
  logic         tmr_load;
  logic [TW-1:0] tmr_val;
  logic         tmr_zero;

  // The timer is reloaded on entry to each timed state: from IDLE for LOAD,
  // from CHECK for PLO, and at the end of PLO for PHI.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(PULSE_HI - 1);
    case (state)
      IDLE:    begin tmr_load = 1'b1; tmr_val = TW'(LD_CYC - 1);   end
      CHECK:   begin tmr_load = 1'b1; tmr_val = TW'(PULSE_LO - 1); end
      PLO:     begin tmr_load = tmr_zero; tmr_val = TW'(PULSE_HI - 1); end
      default: begin tmr_load = 1'b0; tmr_val = TW'(PULSE_HI - 1); end
    endcase
  end

  seq_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .val  (tmr_val),
    .zero (tmr_zero)
  );

  assign clr = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ld      <= 1'b1;
      data    <= '0;
      cpu     <= 1'b1;
      cpd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wrapped <= 1'b0;
      dir_r   <= 1'b0;
      sv_r    <= '0;
      tg_r    <= '0;
      exp_q   <= '0;
    end else if (abort) begin
      state <= IDLE;
      ld    <= 1'b1;
      cpu   <= 1'b1;
      cpd   <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dir_r   <= dir;
            sv_r    <= start_val;
            tg_r    <= target;
            busy    <= 1'b1;
            err     <= 1'b0;
            wrapped <= 1'b0;
            ld      <= 1'b0;
            data    <= start_val;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (tmr_zero) begin
            ld    <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (q != sv_r) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (q == tg_r) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            exp_q <= dir_r ? q + 4'd1 : q - 4'd1;
            cpu   <= ~dir_r;
            cpd   <= dir_r;
            state <= PLO;
          end
        end
        PLO, PHI: begin
          // Carry/borrow is a short low pulse around the wrapping step, so watch the whole pulse.
          if ((dir_r && !qcc) || (!dir_r && !qcb)) wrapped <= 1'b1;
          if (tmr_zero) begin
            if (state == PLO) begin
              cpu   <= 1'b1;
              cpd   <= 1'b1;
              state <= PHI;
            end else if (q != exp_q) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ERR;
            end else begin
              state <= CHECK;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttl74193_seq_ctrl.sv
// Sequencer driving a behavioural ttl74193 counter; per-run results checked from a scoreboard.
module tb_ttl74193_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] start_val = '0;
  logic [3:0] target = '0;
  logic       abort = 1'b0;
  logic [3:0] q;
  logic       qcc, qcb;
  logic       clr, ld, cpu, cpd, busy, done, err, wrapped;
  logic [3:0] data;

  always #5 clk = ~clk;

  ttl74193_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .start_val(start_val),
    .target(target), .abort(abort), .q(q), .qcc(qcc), .qcb(qcb), .clr(clr),
    .ld(ld), .data(data), .cpu(cpu), .cpd(cpd), .busy(busy), .done(done),
    .err(err), .wrapped(wrapped)
  );

  // Counter model: async-style load/clear at clock granularity, steps on pulse falling edge.
  logic [3:0] cq;
  logic       carry_lo, borrow_lo, cpu_q, cpd_q;
  logic       stuck = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cq <= '0; carry_lo <= 1'b0; borrow_lo <= 1'b0; cpu_q <= 1'b1; cpd_q <= 1'b1;
    end else begin
      cpu_q <= cpu;
      cpd_q <= cpd;
      if (clr) cq <= '0;
      else if (!ld) cq <= data;
      else if (!stuck && cpu_q && !cpu) begin cq <= cq + 4'd1; carry_lo <= (cq == 4'd15); end
      else if (!stuck && cpd_q && !cpd) begin cq <= cq - 4'd1; borrow_lo <= (cq == 4'd0); end
      if (cpu && !cpu_q) carry_lo <= 1'b0;
      if (cpd && !cpd_q) borrow_lo <= 1'b0;
    end
  end

  assign q   = cq;
  assign qcc = ~carry_lo;
  assign qcb = ~borrow_lo;

  typedef struct {
    int done; int err; int wrapped; int q; int ncpu; int ncpd; int nld; int lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  int cyc = 0, t0 = 0, n_cpu = 0, n_cpd = 0, n_ld = 0, done_cnt = 0, both_low = 0;
  logic busy_d = 1'b0, cpu_d = 1'b1, cpd_d = 1'b1;

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (!cpu && !cpd) both_low++;
    if (!cpu && cpu_d) n_cpu++;
    if (!cpd && cpd_d) n_cpd++;
    if (!ld) n_ld++;
    if (done) done_cnt++;
    if (rst && busy_d && !busy) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_pulses", done_cnt, e.done);
        chk("err", int'(err), e.err);
        chk("wrapped", int'(wrapped), e.wrapped);
        chk("q_final", int'(q), e.q);
        chk("cpu_pulses", n_cpu, e.ncpu);
        chk("cpd_pulses", n_cpd, e.ncpd);
        chk("ld_low_cycles", n_ld, e.nld);
        if (e.lat >= 0) chk("latency", cyc - t0, e.lat);
      end
    end
    if (rst && start && !busy && !abort) begin
      t0 = cyc; n_cpu = 0; n_cpd = 0; n_ld = 0; done_cnt = 0;
    end
    busy_d = busy;
    cpu_d  = cpu;
    cpd_d  = cpd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t good_run(input logic d, input logic [3:0] sv, input logic [3:0] tg);
    exp_t e;
    logic [3:0] diff;
    diff = d ? tg - sv : sv - tg;
    e.done = 1; e.err = 0; e.q = int'(tg); e.nld = 2;
    e.ncpu = d ? int'(diff) : 0;
    e.ncpd = d ? 0 : int'(diff);
    e.wrapped = d ? int'(int'(sv) + int'(diff) > 15) : int'(int'(diff) > int'(sv));
    e.lat = 5 + 9 * int'(diff);
    return e;
  endfunction

  task automatic drive_start(input logic d, input logic [3:0] sv, input logic [3:0] tg);
    dir = d; start_val = sv; target = tg; start = 1'b1;
  endtask

  task automatic issue(input logic d, input logic [3:0] sv, input logic [3:0] tg);
    drive_start(d, sv, tg);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("run_timeout", sb.size(), 0);
    sb.delete();
    tick();
    tick();
  endtask

  initial begin
    exp_t e;
    int k;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_clr", int'(clr), 0);
    chk("rst_ld", int'(ld), 1);
    chk("rst_data", int'(data), 0);
    chk("rst_cpu", int'(cpu), 1);
    chk("rst_cpd", int'(cpd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wrapped", int'(wrapped), 0);
    tick();
    rst = 1'b1;
    tick();

    // Up 3->7, with a second start mid-run that must be ignored.
    sb.push_back(good_run(1'b1, 4'd3, 4'd7));
    issue(1'b1, 4'd3, 4'd7);
    repeat (8) tick();
    issue(1'b0, 4'd0, 4'd0);
    wait_run(400);

    sb.push_back(good_run(1'b1, 4'd14, 4'd1));
    issue(1'b1, 4'd14, 4'd1);
    wait_run(400);

    sb.push_back(good_run(1'b0, 4'd1, 4'd14));
    issue(1'b0, 4'd1, 4'd14);
    wait_run(400);

    sb.push_back(good_run(1'b1, 4'd9, 4'd9));
    issue(1'b1, 4'd9, 4'd9);
    wait_run(400);

    // Abort during the second pulse of 3->7, then restart the very next cycle.
    e = '{done: 0, err: 0, wrapped: 0, q: 5, ncpu: 2, ncpd: 0, nld: 2, lat: -1};
    sb.push_back(e);
    issue(1'b1, 4'd3, 4'd7);
    k = 0;
    while (n_cpu < 2 && k < 200) begin tick(); k++; end
    chk("abort_reach_pulse2", n_cpu, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.push_back(good_run(1'b0, 4'd5, 4'd4));
    drive_start(1'b0, 4'd5, 4'd4);
    @(negedge clk);
    chk("abort_cpu", int'(cpu), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_q", int'(q), 5);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("restart_busy", int'(busy), 1);
    wait_run(400);

    // Counter stuck after loading 2: first step mismatches and the run errors out.
    stuck = 1'b1;
    e = '{done: 0, err: 1, wrapped: 0, q: 2, ncpu: 1, ncpd: 0, nld: 2, lat: 13};
    sb.push_back(e);
    issue(1'b1, 4'd2, 4'd4);
    wait_run(400);
    chk("err_sticky", int'(err), 1);
    stuck = 1'b0;
    sb.push_back(good_run(1'b1, 4'd2, 4'd4));
    issue(1'b1, 4'd2, 4'd4);
    @(negedge clk);
    chk("err_cleared", int'(err), 0);
    wait_run(400);

    // Asynchronous reset while a pulse is low.
    issue(1'b1, 4'd0, 4'd5);
    k = 0;
    while (!(n_cpu >= 1 && cpu == 1'b0) && k < 200) begin tick(); k++; end
    chk("arst_pulse_seen", int'(cpu), 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cpu", int'(cpu), 1);
    chk("arst_cpd", int'(cpd), 1);
    chk("arst_busy", int'(busy), 0);
    tick();
    rst = 1'b1;
    tick();

    chk("never_both_low", both_low, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
